spectrum_bar_renderer: RTL and testbench



---
 rtl/spectrum_bar_renderer_pkg.sv | 43 ++++
 rtl/spectrum_bar_renderer_bin_ram.sv | 39 +++
 rtl/spectrum_bar_renderer.sv | 195 +++++++++++++++++++
 tb/tb_spectrum_bar_renderer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_bar_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spectrum_pkg
//  Description : Shared constants, types and the colour-zone helper for the
//                spectrum bar renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package spectrum_pkg;

   // Default magnitude width and width of a bin index (64 slots >= 60 bins)
   localparam int DEF_MAG_W = 10;
   localparam int BIN_IDX_W = 6;

   // Bar colours, {R,G,B}
   localparam logic [23:0] COL_LOW  = 24'h00FF00;
   localparam logic [23:0] COL_MID  = 24'hFFFF00;
   localparam logic [23:0] COL_HIGH = 24'hFF0000;
   localparam logic [23:0] COL_BG   = 24'h000000;

   // Height thresholds (pixels above the bottom row) between colour zones
   localparam int ZONE_MID  = 400;
   localparam int ZONE_HIGH = 640;

   // Commit handshake state
   typedef enum logic [0:0] {
      CM_OPEN    = 1'b0,
      CM_PENDING = 1'b1
   } commit_state_t;

   // Colour of a lit pixel at height h above the bottom row
   function automatic logic [23:0] zone_colour(input logic [9:0] h);
      logic [23:0] col;
      if (int'(h) < ZONE_MID)
         col = COL_LOW;
      else if (int'(h) < ZONE_HIGH)
         col = COL_MID;
      else
         col = COL_HIGH;
      return col;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spectrum_bar_renderer_bin_ram.sv
`default_nettype none
// ============================================================================
//  Module      : spectrum_bin_ram
//  Description : Dual-bank bin magnitude RAM. Simple dual-port, synchronous
//                read; the address MSB selects the bank. Only the first
//                N_BINS entries of each half are ever written. No reset so it
//                maps onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module spectrum_bin_ram #(
   parameter int ADDR_W = 7,
   parameter int MAG_W  = 10
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [MAG_W-1:0]  i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [MAG_W-1:0]  o_rd_data
);

   logic [MAG_W-1:0] r_mem [2**ADDR_W];
   logic [MAG_W-1:0] r_rd_data;

   // Write port: back bank updates from the FFT magnitude stage
   always_ff @(posedge clk) begin
      if (i_wr_en)
         r_mem[i_wr_addr] <= i_wr_data;
   end

   // Read port: front bank lookup, one cycle latency
   always_ff @(posedge clk) begin
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/spectrum_bar_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : spectrum_bar_renderer
//  Description : Renders a vertical bar-graph spectrum (one bar per bin,
//                growing upward) from video timing and pixel coordinates.
//                Two-stage pipeline; double-buffered bin RAM swapped on the
//                vsync falling edge after a commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module spectrum_bar_renderer
   import spectrum_pkg::*;
#(
   parameter int N_BINS     = 60,
   parameter int BAR_W_LOG2 = 3,
   parameter int MAG_W      = DEF_MAG_W,
   parameter int H_ACTIVE   = 480,
   parameter int V_ACTIVE   = 800
) (
   input  logic                 clk_pixel,
   input  logic                 rst_n,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   input  logic                 active_in,
   input  logic [9:0]           pixel_x,
   input  logic [9:0]           pixel_y,
   input  logic                 bin_wr_valid,
   output logic                 bin_wr_ready,
   input  logic [BIN_IDX_W-1:0] bin_wr_addr,
   input  logic [MAG_W-1:0]     bin_wr_data,
   input  logic                 bin_commit,
   output logic                 hsync_out,
   output logic                 vsync_out,
   output logic                 active_out,
   output logic [23:0]          rgb,
   output logic                 frame_swapped
);

   localparam int ADDR_W  = BIN_IDX_W + 1;
   localparam int GAP_COL = (1 << BAR_W_LOG2) - 1;

   // Bars must tile the active line exactly and bins must fit the index
   generate
      if ((N_BINS * (1 << BAR_W_LOG2) != H_ACTIVE) || (N_BINS > (1 << BIN_IDX_W))) begin : g_geometry_check
         $error("spectrum_bar_renderer: bar geometry does not match H_ACTIVE");
      end
   endgenerate

   // ---------------------------------------------------------------- state
   commit_state_t          r_cm_state;
   commit_state_t          w_cm_next;
   logic                   w_swap;
   logic                   r_front_sel;
   logic                   r_front_valid;
   logic                   r_frame_swapped;

   logic                   r_s1_hsync;
   logic                   r_s1_vsync;
   logic                   r_s1_active;
   logic [9:0]             r_s1_y;
   logic [BAR_W_LOG2-1:0]  r_s1_xoff;

   logic                   r_hsync_out;
   logic                   r_vsync_out;
   logic                   r_active_out;
   logic [23:0]            r_rgb;

   // ---------------------------------------------------------------- RAM
   logic [9:0]             w_bin_full;
   logic [ADDR_W-1:0]      w_rd_addr;
   logic [ADDR_W-1:0]      w_wr_addr;
   logic                   w_wr_en;
   logic [MAG_W-1:0]       w_ram_q;
   logic                   w_unused_bin;

   assign w_bin_full   = pixel_x >> BAR_W_LOG2;
   assign w_rd_addr    = {r_front_sel, w_bin_full[BIN_IDX_W-1:0]};
   assign w_unused_bin = ^w_bin_full[9:BIN_IDX_W];

   // Writes always land in the back bank; out-of-range bins are swallowed
   assign bin_wr_ready = (r_cm_state == CM_OPEN);
   assign w_wr_en      = bin_wr_valid && bin_wr_ready && (int'(bin_wr_addr) < N_BINS);
   assign w_wr_addr    = {~r_front_sel, bin_wr_addr};

   spectrum_bin_ram #(
      .ADDR_W (ADDR_W),
      .MAG_W  (MAG_W)
   ) u_bin_ram (
      .clk       (clk_pixel),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (bin_wr_data),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_ram_q)
   );

   // ---------------------------------------------------------------- commit / swap
   // r_s1_vsync is the registered vsync_in, so this is its 1->0 edge
   logic w_vs_fall;
   assign w_vs_fall = r_s1_vsync & ~vsync_in;

   // Commit state register
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n)
         r_cm_state <= CM_OPEN;
      else
         r_cm_state <= w_cm_next;
   end

   // Commit next-state: latch a commit, release it at the next vsync edge
   always_comb begin
      w_cm_next = r_cm_state;
      w_swap    = 1'b0;
      case (r_cm_state)
         CM_OPEN: begin
            if (bin_commit)
               w_cm_next = CM_PENDING;
         end
         CM_PENDING: begin
            if (w_vs_fall) begin
               w_swap    = 1'b1;
               w_cm_next = CM_OPEN;
            end
         end
         default: w_cm_next = CM_OPEN;
      endcase
   end

   // Front bank selection, validity and the swap pulse
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         r_front_sel     <= 1'b0;
         r_front_valid   <= 1'b0;
         r_frame_swapped <= 1'b0;
      end else begin
         r_frame_swapped <= w_swap;
         if (w_swap) begin
            r_front_sel   <= ~r_front_sel;
            r_front_valid <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- stage 1
   // Stage 1: align timing and coordinates with the RAM read
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_hsync  <= 1'b1;
         r_s1_vsync  <= 1'b1;
         r_s1_active <= 1'b0;
         r_s1_y      <= '0;
         r_s1_xoff   <= '0;
      end else begin
         r_s1_hsync  <= hsync_in;
         r_s1_vsync  <= vsync_in;
         r_s1_active <= active_in;
         r_s1_y      <= pixel_y;
         r_s1_xoff   <= pixel_x[BAR_W_LOG2-1:0];
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [9:0]       w_h;
   logic [MAG_W-1:0] w_mag;
   logic             w_lit;
   logic [23:0]      w_colour;

   // Height above the bottom row; only meaningful while active
   assign w_h      = 10'(V_ACTIVE - 1) - r_s1_y;
   assign w_mag    = r_front_valid ? w_ram_q : '0;
   assign w_lit    = r_s1_active && (int'(r_s1_xoff) != GAP_COL) && (int'(w_h) < int'(w_mag));
   assign w_colour = zone_colour(w_h);

   // Stage 2: colour decision and the matching sync/active delay
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         r_hsync_out  <= 1'b1;
         r_vsync_out  <= 1'b1;
         r_active_out <= 1'b0;
         r_rgb        <= COL_BG;
      end else begin
         r_hsync_out  <= r_s1_hsync;
         r_vsync_out  <= r_s1_vsync;
         r_active_out <= r_s1_active;
         r_rgb        <= w_lit ? w_colour : COL_BG;
      end
   end

   assign hsync_out     = r_hsync_out;
   assign vsync_out     = r_vsync_out;
   assign active_out    = r_active_out;
   assign rgb           = r_rgb;
   assign frame_swapped = r_frame_swapped;

endmodule
`default_nettype wire

// File: tb/tb_spectrum_bar_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spectrum_bar_renderer
//  Description : Self-checking bench for spectrum_bar_renderer. Randomized
//                frames and bin traffic checked against a behavioural model
//                of the display and the double-buffered bins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spectrum_bar_renderer;

   logic        clk_pixel = 1'b0;
   logic        rst_n     = 1'b0;
   logic        hsync_in  = 1'b1;
   logic        vsync_in  = 1'b1;
   logic        active_in = 1'b0;
   logic [9:0]  pixel_x   = '0;
   logic [9:0]  pixel_y   = '0;
   logic        bin_wr_valid = 1'b0;
   logic        bin_wr_ready;
   logic [5:0]  bin_wr_addr = '0;
   logic [9:0]  bin_wr_data = '0;
   logic        bin_commit  = 1'b0;
   logic        hsync_out;
   logic        vsync_out;
   logic        active_out;
   logic [23:0] rgb;
   logic        frame_swapped;

   spectrum_bar_renderer u_dut (
      .clk_pixel     (clk_pixel),
      .rst_n         (rst_n),
      .hsync_in      (hsync_in),
      .vsync_in      (vsync_in),
      .active_in     (active_in),
      .pixel_x       (pixel_x),
      .pixel_y       (pixel_y),
      .bin_wr_valid  (bin_wr_valid),
      .bin_wr_ready  (bin_wr_ready),
      .bin_wr_addr   (bin_wr_addr),
      .bin_wr_data   (bin_wr_data),
      .bin_commit    (bin_commit),
      .hsync_out     (hsync_out),
      .vsync_out     (vsync_out),
      .active_out    (active_out),
      .rgb           (rgb),
      .frame_swapped (frame_swapped)
   );

   always #5 clk_pixel = ~clk_pixel;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        act;
      logic [23:0] col;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Reference model: physical bank contents plus the display bookkeeping
   int   m_bank [2][60];
   bit   m_sel;
   bit   m_fv;
   bit   m_pend;
   bit   m_prev_vs;
   int   fill_v [60];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected colour of a pixel from the bar-graph rules
   function automatic logic [23:0] ref_rgb(input int x, input int y, input bit act);
      int h;
      int mag;
      if (!act) return 24'h000000;
      if (x % 8 == 7) return 24'h000000;
      mag = m_fv ? m_bank[m_sel][x / 8] : 0;
      h   = 799 - y;
      if (h >= mag) return 24'h000000;
      if (h < 400) return 24'h00FF00;
      if (h < 640) return 24'hFFFF00;
      return 24'hFF0000;
   endfunction

   function automatic exp_t reset_entry();
      exp_t e;
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.act = 1'b0;
      e.col = 24'h000000;
      return e;
   endfunction

   // One clock: record expectation, advance, update model, compare
   task automatic step();
      exp_t e;
      bit   swap;
      e.hs  = hsync_in;
      e.vs  = vsync_in;
      e.act = active_in;
      e.col = ref_rgb(int'(pixel_x), int'(pixel_y), active_in);
      exp_q.push_back(e);
      @(posedge clk_pixel);
      #1;
      swap = m_prev_vs && !vsync_in && m_pend;
      if (bin_wr_valid && !m_pend && int'(bin_wr_addr) < 60)
         m_bank[!m_sel][bin_wr_addr] = int'(bin_wr_data);
      if (swap) begin
         m_sel  = !m_sel;
         m_fv   = 1'b1;
         m_pend = 1'b0;
      end else if (bin_commit) begin
         m_pend = 1'b1;
      end
      m_prev_vs = vsync_in;
      e = exp_q.pop_front();
      check("hsync_out",     32'(hsync_out),     32'(e.hs));
      check("vsync_out",     32'(vsync_out),     32'(e.vs));
      check("active_out",    32'(active_out),    32'(e.act));
      check("rgb",           32'(rgb),           32'(e.col));
      check("frame_swapped", 32'(frame_swapped), 32'(swap));
      check("bin_wr_ready",  32'(bin_wr_ready),  32'(!m_pend));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_hsync"},  32'(hsync_out),     32'd1);
      check({tag, "_vsync"},  32'(vsync_out),     32'd1);
      check({tag, "_active"}, 32'(active_out),    32'd0);
      check({tag, "_rgb"},    32'(rgb),           32'd0);
      check({tag, "_swap"},   32'(frame_swapped), 32'd0);
      check({tag, "_ready"},  32'(bin_wr_ready),  32'd1);
   endtask

   // Async reset asserted between clock edges, held two edges, then released
   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      @(posedge clk_pixel);
      @(posedge clk_pixel);
      #1;
      check_reset_outputs({tag, "_held"});
      m_sel     = 1'b0;
      m_fv      = 1'b0;
      m_pend    = 1'b0;
      m_prev_vs = 1'b1;
      exp_q.delete();
      exp_q.push_back(reset_entry());
      active_in    = 1'b0;
      bin_wr_valid = 1'b0;
      bin_commit   = 1'b0;
      hsync_in     = 1'b1;
      vsync_in     = 1'b1;
      rst_n        = 1'b1;
   endtask

   // Write-port traffic: 0 idle, 1 random, 2 held valid
   task automatic drive_wr(input int wmode);
      bin_wr_valid = (wmode == 2) ? 1'b1 : (wmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bin_wr_addr  = 6'($urandom_range(0, 63));
      bin_wr_data  = 10'($urandom_range(0, 1023));
   endtask

   task automatic fill_random();
      for (int i = 0; i < 60; i++) fill_v[i] = $urandom_range(0, 1023);
   endtask

   task automatic fill_all();
      active_in = 1'b0;
      for (int i = 0; i < 60; i++) begin
         bin_wr_valid = 1'b1;
         bin_wr_addr  = 6'(i);
         bin_wr_data  = 10'(fill_v[i]);
         step();
      end
      bin_wr_valid = 1'b0;
   endtask

   task automatic commit();
      bin_commit = 1'b1;
      step();
      bin_commit = 1'b0;
   endtask

   // Vertical blanking with a vsync pulse; optional commit on the falling edge
   task automatic frame(input bit cm_on_fall, input int wmode);
      active_in = 1'b0;
      for (int i = 0; i < 12; i++) begin
         vsync_in   = (i >= 4 && i < 8) ? 1'b0 : 1'b1;
         hsync_in   = ($urandom_range(0, 2) != 0);
         bin_commit = (i == 4) ? cm_on_fall : 1'b0;
         drive_wr(wmode);
         step();
      end
      bin_commit   = 1'b0;
      bin_wr_valid = 1'b0;
      vsync_in     = 1'b1;
      hsync_in     = 1'b1;
   endtask

   task automatic rand_pixels(input int n, input int wmode);
      for (int i = 0; i < n; i++) begin
         active_in = 1'b1;
         hsync_in  = 1'b1;
         vsync_in  = 1'b1;
         pixel_x   = 10'($urandom_range(0, 479));
         pixel_y   = 10'($urandom_range(0, 799));
         drive_wr(wmode);
         step();
      end
      active_in    = 1'b0;
      bin_wr_valid = 1'b0;
   endtask

   // First two bars across the zone boundaries and the gap column
   task automatic sweep();
      int ys [10];
      ys = '{0, 159, 160, 399, 400, 639, 640, 699, 700, 799};
      for (int x = 0; x < 16; x++) begin
         for (int k = 0; k < 10; k++) begin
            active_in = 1'b1;
            pixel_x   = 10'(x);
            pixel_y   = 10'(ys[k]);
            step();
         end
      end
      active_in = 1'b0;
   endtask

   initial begin
      m_sel = 1'b0; m_fv = 1'b0; m_pend = 1'b0; m_prev_vs = 1'b1;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 60; i++) m_bank[b][i] = 0;

      // Power-on reset
      @(posedge clk_pixel);
      #1;
      do_reset("por");

      // No commit: black frame, sync delayed by two
      frame(1'b0, 0);
      rand_pixels(200, 0);

      // bin0=100, bin1=800 then commit and swap
      fill_random();
      fill_v[0] = 100;
      fill_v[1] = 800;
      fill_all();
      commit();
      frame(1'b0, 0);
      sweep();
      rand_pixels(200, 1);

      // Commit then hold valid high: nothing lands until the swap
      fill_random();
      fill_all();
      commit();
      for (int i = 0; i < 20; i++) begin
         drive_wr(2);
         step();
      end
      frame(1'b0, 2);
      rand_pixels(300, 0);

      // Commit on the vsync falling edge: swap deferred one frame
      fill_random();
      fill_all();
      frame(1'b1, 0);
      rand_pixels(100, 0);
      frame(1'b0, 0);
      rand_pixels(300, 0);

      // Out-of-range bin write is discarded
      fill_random();
      fill_all();
      bin_wr_valid = 1'b1;
      bin_wr_addr  = 6'd63;
      bin_wr_data  = 10'd1023;
      step();
      bin_wr_valid = 1'b0;
      commit();
      frame(1'b0, 0);
      sweep();
      rand_pixels(300, 0);

      // Reset mid active line, then black until a new committed swap
      rand_pixels(50, 0);
      active_in = 1'b1;
      pixel_x   = 10'd8;
      pixel_y   = 10'd799;
      step();
      do_reset("mid");
      frame(1'b0, 1);
      rand_pixels(200, 1);
      fill_random();
      fill_all();
      commit();
      frame(1'b0, 1);
      rand_pixels(300, 1);

      // Random frames with random traffic and occasional commits
      for (int it = 0; it < 8; it++) begin
         fill_random();
         fill_all();
         if ($urandom_range(0, 1) == 1) commit();
         frame(1'($urandom_range(0, 3) == 0), 1);
         rand_pixels(400, 1);
      end
      frame(1'b0, 0);
      rand_pixels(100, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
